// File: rtl/vend_customer_driver.sv
// Scripted vending-machine customer: card, two key strobes, payment, door.
// Optional VEND_DRV_RETRY_EN replays the card/key sequence once after a failed payment.
module vend_customer_driver #(
  parameter int KEY_GAP      = 1,
  parameter int DOOR_DLY     = 1,
  parameter int DOOR_HOLD    = 1,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] REQ_CODE,
  input  logic       WALLET_OK,
  input  logic       VEND,
  input  logic       INVALID_SEL,
  input  logic [2:0] COST,
  input  logic       FAILED_TRAN,
  output logic       CARD_IN,
  output logic       KEY_PRESS,
  output logic [3:0] ITEM_CODE,
  output logic       VALID_TRAN,
  output logic       DOOR_OPEN,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] RESULT,
  output logic [7:0] SPENT
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CARD  = 4'd1;
  localparam logic [3:0] S_GAP0  = 4'd2;
  localparam logic [3:0] S_KEY1  = 4'd3;
  localparam logic [3:0] S_GAP1  = 4'd4;
  localparam logic [3:0] S_KEY2  = 4'd5;
  localparam logic [3:0] S_WAIT  = 4'd6;
  localparam logic [3:0] S_DWAIT = 4'd7;
  localparam logic [3:0] S_DOOR  = 4'd8;
  localparam logic [3:0] S_FIN   = 4'd9;
`ifdef VEND_DRV_RETRY_EN
  localparam logic [3:0] S_RGAP  = 4'd10;
`endif

  localparam int CW = 8;
  localparam logic [CW-1:0] KG_END = CW'(KEY_GAP - 1);
  localparam logic [CW-1:0] DD_END = CW'(DOOR_DLY - 1);
  localparam logic [CW-1:0] DH_END = CW'(DOOR_HOLD - 1);
  localparam logic [CW-1:0] TO_END = CW'(RESP_TIMEOUT - 1);

  logic [3:0]    state;
  logic [3:0]    state_d;
  logic [CW-1:0] cnt;
  logic [7:0]    code_q;
  logic          wallet_q;
  logic [2:0]    cost_q;
  logic [1:0]    res_d;
  logic          valid_d;
  logic [8:0]    sum;
  logic [7:0]    spent_d;

`ifdef VEND_DRV_RETRY_EN
  logic retried;
`endif

  always_comb begin
    state_d = state;
    res_d   = RESULT;
    unique case (state)
      S_IDLE:  if (START) state_d = S_CARD;
      S_CARD:  state_d = S_GAP0;
      S_GAP0:  if (cnt == KG_END) state_d = S_KEY1;
      S_KEY1:  state_d = S_GAP1;
      S_GAP1:  if (cnt == KG_END) state_d = S_KEY2;
      S_KEY2:  state_d = S_WAIT;
      S_WAIT: begin
        if (INVALID_SEL) begin
          state_d = S_FIN;
          res_d   = 2'b01;
        end else if (FAILED_TRAN) begin
          state_d = S_FIN;
          res_d   = 2'b10;
`ifdef VEND_DRV_RETRY_EN
          if (!retried) state_d = S_RGAP;
`endif
        end else if (VEND) begin
          state_d = S_DWAIT;
        end else if (cnt == TO_END) begin
          state_d = S_FIN;
          res_d   = 2'b11;
        end
      end
      S_DWAIT: if (cnt == DD_END) state_d = S_DOOR;
      S_DOOR: begin
        if (cnt == DH_END) begin
          state_d = S_FIN;
          res_d   = 2'b00;
        end
      end
      S_FIN:   state_d = S_IDLE;
`ifdef VEND_DRV_RETRY_EN
      S_RGAP:  if (cnt == KG_END) state_d = S_CARD;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Payment stays authorised only while still waiting for the machine.
  assign valid_d = (state == S_WAIT) && (state_d == S_WAIT) &&
                   (VALID_TRAN || ((COST != 3'd0) && wallet_q));

  assign sum     = {1'b0, SPENT} + {6'd0, cost_q};
  assign spent_d = sum[8] ? 8'hFF : sum[7:0];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      code_q     <= '0;
      wallet_q   <= 1'b0;
      cost_q     <= '0;
      ITEM_CODE  <= '0;
      VALID_TRAN <= 1'b0;
      RESULT     <= '0;
      SPENT      <= '0;
    end else begin
      state      <= state_d;
      VALID_TRAN <= valid_d;
      if ((state_d != state) || (state == S_IDLE))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if ((state == S_IDLE) && START) begin
        code_q   <= REQ_CODE;
        wallet_q <= WALLET_OK;
      end
      if (state_d == S_KEY1) ITEM_CODE <= code_q[7:4];
      if (state_d == S_KEY2) ITEM_CODE <= code_q[3:0];
      if ((state == S_WAIT) && (state_d == S_DWAIT))
        cost_q <= COST;
      if ((state_d == S_FIN) && (state != S_FIN))
        RESULT <= res_d;
      if ((state == S_DOOR) && (state_d == S_FIN))
        SPENT <= spent_d;
    end
  end

`ifdef VEND_DRV_RETRY_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      retried <= 1'b0;
    else if (state == S_IDLE)
      retried <= 1'b0;
    else if ((state == S_WAIT) && (state_d == S_RGAP))
      retried <= 1'b1;
  end
`endif

  assign CARD_IN   = (state == S_CARD);
  assign KEY_PRESS = (state == S_KEY1) || (state == S_KEY2);
  assign DOOR_OPEN = (state == S_DOOR);
  assign DONE      = (state == S_FIN);
  assign BUSY      = (state != S_IDLE) && (state != S_FIN);

endmodule

// File: tb/tb_vend_customer_driver.sv
// Bench for vend_customer_driver: per-transaction timeline model, per-cycle compare.
// Default build (VEND_DRV_RETRY_EN undefined).
module tb_vend_customer_driver;

  localparam int KG = 1;
  localparam int DD = 1;
  localparam int DH = 1;
  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic [7:0] REQ_CODE = '0;
  logic       WALLET_OK = 1'b0;
  logic       VEND = 1'b0;
  logic       INVALID_SEL = 1'b0;
  logic [2:0] COST = '0;
  logic       FAILED_TRAN = 1'b0;
  logic       CARD_IN;
  logic       KEY_PRESS;
  logic [3:0] ITEM_CODE;
  logic       VALID_TRAN;
  logic       DOOR_OPEN;
  logic       BUSY;
  logic       DONE;
  logic [1:0] RESULT;
  logic [7:0] SPENT;

  vend_customer_driver #(
    .KEY_GAP(KG), .DOOR_DLY(DD), .DOOR_HOLD(DH), .RESP_TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .REQ_CODE(REQ_CODE),
    .WALLET_OK(WALLET_OK), .VEND(VEND), .INVALID_SEL(INVALID_SEL),
    .COST(COST), .FAILED_TRAN(FAILED_TRAN), .CARD_IN(CARD_IN),
    .KEY_PRESS(KEY_PRESS), .ITEM_CODE(ITEM_CODE), .VALID_TRAN(VALID_TRAN),
    .DOOR_OPEN(DOOR_OPEN), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .SPENT(SPENT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  logic [7:0] e_card[64], e_key[64], e_item[64], e_valid[64], e_door[64];
  logic [7:0] e_busy[64], e_done[64], e_res[64], e_spent[64];
  int cyc = 0;
  bit active = 1'b0;

  int m_spent = 0;
  int m_result = 0;
  int m_item = 0;

  always @(negedge CLK) begin
    if (active) begin
      check("card_in",    8'(CARD_IN),    e_card[cyc]);
      check("key_press",  8'(KEY_PRESS),  e_key[cyc]);
      check("item_code",  8'(ITEM_CODE),  e_item[cyc]);
      check("valid_tran", 8'(VALID_TRAN), e_valid[cyc]);
      check("door_open",  8'(DOOR_OPEN),  e_door[cyc]);
      check("busy",       8'(BUSY),       e_busy[cyc]);
      check("done",       8'(DONE),       e_done[cyc]);
      check("result",     8'(RESULT),     e_res[cyc]);
      check("spent",      SPENT,          e_spent[cyc]);
    end
  end

  int card_cnt = 0;
  int done_cnt = 0;
  always @(negedge CLK) begin
    if (CARD_IN === 1'b1) card_cnt++;
    if (DONE === 1'b1) done_cnt++;
  end

  // kind: 0 vend, 1 invalid_sel, 2 failed_tran, 3 timeout.
  // d: wait-cycles after entering the response phase before the machine answers.
  // pri: also raise the lower-priority responses in the same cycle.
  task automatic txn(input logic [7:0] code, input bit wallet, input int kind,
                     input int d, input logic [2:0] cost, input bit extra,
                     input bit pri);
    int k1, k2, w, rc, fin, ns;
    k1 = 2 + KG;
    k2 = k1 + 1 + KG;
    w = k2 + 1;
    rc = (kind == 3) ? w + TO - 1 : w + d;
    if (kind == 0) fin = rc + 1 + DD + DH;
    else if (kind == 3) fin = w + TO;
    else fin = rc + 1;
    ns = (m_spent + int'(cost) > 255) ? 255 : m_spent + int'(cost);
    for (int c = 0; c <= fin + 1; c++) begin
      e_card[c]  = 8'(c == 1);
      e_key[c]   = 8'((c == k1) || (c == k2));
      e_item[c]  = (c < k1) ? 8'(m_item) :
                   (c < k2) ? 8'(code[7:4]) : 8'(code[3:0]);
      e_valid[c] = 8'(wallet && (cost != 0) && (c >= w + 1) && (c <= rc));
      e_door[c]  = 8'((kind == 0) && (c >= rc + 1 + DD) && (c < fin));
      e_busy[c]  = 8'((c >= 1) && (c < fin));
      e_done[c]  = 8'(c == fin);
      e_res[c]   = (c >= fin) ? 8'(kind) : 8'(m_result);
      e_spent[c] = ((c >= fin) && (kind == 0)) ? 8'(ns) : 8'(m_spent);
    end
    for (int c = 0; c <= fin + 1; c++) begin
      @(posedge CLK);
      #1;
      cyc = c;
      active = 1'b1;
      START = (c == 0) || (extra && ((c == 2) || (c == fin)));
      REQ_CODE = code;
      WALLET_OK = wallet;
      COST = ((c >= w) && (c <= rc)) ? cost : 3'd0;
      VEND = (c == rc) && ((kind == 0) || pri);
      FAILED_TRAN = (c == rc) && ((kind == 2) || (pri && (kind == 1)));
      INVALID_SEL = (c == rc) && (kind == 1);
    end
    @(negedge CLK);
    #1;
    active = 1'b0;
    START = 1'b0;
    COST = '0;
    VEND = 1'b0;
    FAILED_TRAN = 1'b0;
    INVALID_SEL = 1'b0;
    m_item = int'(code[3:0]);
    m_result = kind;
    if (kind == 0) m_spent = ns;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    m_spent = 0;
    m_result = 0;
    m_item = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end in time");
    $fatal(1);
  end

  initial begin
    int c0, d0;
    repeat (2) @(negedge CLK);
    check("rst_card",  8'(CARD_IN), 8'd0);
    check("rst_key",   8'(KEY_PRESS), 8'd0);
    check("rst_item",  8'(ITEM_CODE), 8'd0);
    check("rst_valid", 8'(VALID_TRAN), 8'd0);
    check("rst_door",  8'(DOOR_OPEN), 8'd0);
    check("rst_busy",  8'(BUSY), 8'd0);
    check("rst_done",  8'(DONE), 8'd0);
    check("rst_res",   8'(RESULT), 8'd0);
    check("rst_spent", SPENT, 8'd0);
    RESET = 1'b1;

    // T1: vend of item 13 at cost 3
    c0 = card_cnt;
    d0 = done_cnt;
    txn(8'h13, 1'b1, 0, 2, 3'd3, 1'b0, 1'b0);
    check("t1_spent", SPENT, 8'd3);
    check("t1_result", 8'(RESULT), 8'd0);
    check("t1_cards", 8'(card_cnt - c0), 8'd1);
    check("t1_dones", 8'(done_cnt - d0), 8'd1);

    // T2: invalid selection
    txn(8'h42, 1'b1, 1, 2, 3'd0, 1'b0, 1'b0);
    check("t2_result", 8'(RESULT), 8'd1);

    // T3: unfunded card, payment fails
    txn(8'h77, 1'b0, 2, 5, 3'd5, 1'b0, 1'b0);
    check("t3_result", 8'(RESULT), 8'd2);
    check("t3_spent", SPENT, 8'd3);

    // T4: timeout, with extra STARTs while busy and on the finish cycle
    c0 = card_cnt;
    txn(8'h21, 1'b1, 3, 0, 3'd0, 1'b1, 1'b0);
    check("t4_result", 8'(RESULT), 8'd3);
    check("t4_cards", 8'(card_cnt - c0), 8'd1);
    txn(8'h99, 1'b1, 3, 0, 3'd2, 1'b0, 1'b0);

    // Simultaneous responses
    txn(8'h55, 1'b1, 1, 1, 3'd0, 1'b0, 1'b1);
    check("pri_invalid", 8'(RESULT), 8'd1);
    txn(8'h56, 1'b1, 2, 3, 3'd4, 1'b0, 1'b1);
    check("pri_failed", 8'(RESULT), 8'd2);
    check("pri_spent", SPENT, 8'd3);

    // T5: saturation from zero
    do_reset();
    for (int i = 0; i < 86; i++)
      txn(8'h13, 1'b1, 0, 0, 3'd3, 1'b0, 1'b0);
    check("t5_spent_sat", SPENT, 8'd255);

    // Reset during KEY1
    d0 = done_cnt;
    @(posedge CLK); #1;
    START = 1'b1;
    REQ_CODE = 8'hA5;
    WALLET_OK = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #2;
    check("mid_key1_key", 8'(KEY_PRESS), 8'd1);
    check("mid_key1_item", 8'(ITEM_CODE), 8'hA);
    RESET = 1'b0;
    #1;
    check("mid_rst_key",   8'(KEY_PRESS), 8'd0);
    check("mid_rst_item",  8'(ITEM_CODE), 8'd0);
    check("mid_rst_card",  8'(CARD_IN), 8'd0);
    check("mid_rst_valid", 8'(VALID_TRAN), 8'd0);
    check("mid_rst_door",  8'(DOOR_OPEN), 8'd0);
    check("mid_rst_busy",  8'(BUSY), 8'd0);
    check("mid_rst_done",  8'(DONE), 8'd0);
    check("mid_rst_res",   8'(RESULT), 8'd0);
    check("mid_rst_spent", SPENT, 8'd0);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (4) @(negedge CLK);
    check("post_rst_dones", 8'(done_cnt - d0), 8'd0);
    check("post_rst_busy", 8'(BUSY), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
